// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Issue/hazard controller for the decode stage. A per-register scoreboard
//   counts writes that have been issued but not yet written back. Decode is
//   stalled on RAW hazards, on a saturated destination counter and while a
//   HALT drains. A bubble is loaded into ID->EX whenever the decode slot does
//   not issue, including when a taken branch from EX kills that slot.
//
// Parameters
//   ADDR_LINE  register-address width (2**ADDR_LINE architectural registers)
//   CNT_W      width of each pending-write counter
//
// Ports
//   clk              in   pipeline clock
//   reset            in   asynchronous, active-low reset
//   inst_valid_f_if  in   inst_f_if holds a real instruction
//   inst_f_if        in   instruction currently in decode
//   w_f_wb           in   WB stage writes the register file this cycle
//   addr_in_f_wb     in   WB destination register
//   flush_f_ex       in   taken branch/JR in EX, kill the decode slot
//   stall_2_if       out  hold PC and the IF/ID register
//   bubble_2_ex      out  load a NOP into ID->EX
//   halted           out  core halted with all writes retired
//   sb_err           out  sticky: write-back to a register with no pending write
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int ADDR_LINE = 5,
  parameter int CNT_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 inst_valid_f_if,
  input  logic [31:0]          inst_f_if,
  input  logic                 w_f_wb,
  input  logic [ADDR_LINE-1:0] addr_in_f_wb,
  input  logic                 flush_f_ex,
  output logic                 stall_2_if,
  output logic                 bubble_2_ex,
  output logic                 halted,
  output logic                 sb_err
);

  localparam int NREG = 1 << ADDR_LINE;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_DRAIN  = 2'b01,
    ST_HALTED = 2'b10
  } state_e;

  state_e                         state_q;
  logic                           sb_err_q;
  logic [NREG-1:0][CNT_W-1:0]     cnt_q;
  logic [NREG-1:0][CNT_W-1:0]     cnt_d;

  logic [5:0]           opcode_s;
  logic [ADDR_LINE-1:0] rs_s;
  logic [ADDR_LINE-1:0] rt_s;
  logic [ADDR_LINE-1:0] rd_s;
  logic [ADDR_LINE-1:0] dst_s;
  logic                 src_a_v_s;
  logic                 src_b_v_s;
  logic                 dst_v_s;
  logic                 is_halt_s;
  logic                 src_a_chk_s;
  logic                 src_b_chk_s;
  logic                 dst_chk_s;
  logic                 hazard_s;
  logic                 issue_s;
  logic                 wb_hit_s;
  logic                 wb_dec_s;
  logic                 wb_err_s;
  logic [NREG-1:0]      inc_s;
  logic [NREG-1:0]      dec_s;
  logic                 drain_done_s;
  logic                 unused_imm_s;

  assign opcode_s = inst_f_if[31:26];
  assign rs_s     = inst_f_if[21 +: ADDR_LINE];
  assign rt_s     = inst_f_if[16 +: ADDR_LINE];
  assign rd_s     = inst_f_if[11 +: ADDR_LINE];
  assign unused_imm_s = ^inst_f_if[10:0];

  // Opcode decode: which register fields are read and which one is written.
  always_comb begin
    src_a_v_s = 1'b0;
    src_b_v_s = 1'b0;
    dst_v_s   = 1'b0;
    is_halt_s = 1'b0;
    dst_s     = rd_s;
    case (opcode_s)
      6'b000000, 6'b000010, 6'b000100,
      6'b000110, 6'b001000, 6'b001010: begin
        src_a_v_s = 1'b1;
        src_b_v_s = 1'b1;
        dst_v_s   = 1'b1;
        dst_s     = rd_s;
      end
      6'b000001, 6'b000011, 6'b000101, 6'b000111,
      6'b001001, 6'b001011, 6'b001100: begin
        src_a_v_s = 1'b1;
        dst_v_s   = 1'b1;
        dst_s     = rt_s;
      end
      6'b001101, 6'b001111: begin
        src_a_v_s = 1'b1;
        src_b_v_s = 1'b1;
      end
      6'b001110, 6'b010000: begin
        src_a_v_s = 1'b1;
      end
      6'b010001: begin
        is_halt_s = 1'b1;
      end
      default: begin
        src_a_v_s = 1'b0;
        src_b_v_s = 1'b0;
        dst_v_s   = 1'b0;
        is_halt_s = 1'b0;
      end
    endcase
  end

  // r0 is hard-wired, so it is never tracked.
  assign src_a_chk_s = src_a_v_s & (rs_s  != '0);
  assign src_b_chk_s = src_b_v_s & (rt_s  != '0);
  assign dst_chk_s   = dst_v_s   & (dst_s != '0);

  // Uses registered counts only: a WB in this cycle lands at the edge, so the
  // dependent instruction issues one cycle later.
  assign hazard_s = inst_valid_f_if &
                    ((src_a_chk_s & (cnt_q[rs_s]  != '0)) |
                     (src_b_chk_s & (cnt_q[rt_s]  != '0)) |
                     (dst_chk_s   & (cnt_q[dst_s] == CNT_MAX)));

  // Gated by reset so that an instruction presented during reset bubbles.
  assign issue_s = reset & inst_valid_f_if & ~hazard_s & ~flush_f_ex &
                   (state_q == ST_RUN);

  assign wb_hit_s = w_f_wb & (addr_in_f_wb != '0);
  assign wb_dec_s = wb_hit_s & (cnt_q[addr_in_f_wb] != '0);
  assign wb_err_s = wb_hit_s & (cnt_q[addr_in_f_wb] == '0);

  assign inc_s = (issue_s & dst_chk_s) ? (NREG'(1) << dst_s)        : '0;
  assign dec_s = wb_dec_s              ? (NREG'(1) << addr_in_f_wb) : '0;

  // Scoreboard next state; an issue and a retire on one register cancel.
  always_comb begin
    cnt_d = cnt_q;
    for (int r = 0; r < NREG; r++) begin
      case ({inc_s[r], dec_s[r]})
        2'b10:   cnt_d[r] = cnt_q[r] + CNT_W'(1);
        2'b01:   cnt_d[r] = cnt_q[r] - CNT_W'(1);
        default: cnt_d[r] = cnt_q[r];
      endcase
    end
  end

  // Drain completes as soon as the last retire has landed.
  assign drain_done_s = (cnt_d == '0);

  // Scoreboard, sticky error flag and RUN/DRAIN/HALTED state machine.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      sb_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (wb_err_s) begin
        sb_err_q <= 1'b1;
      end
      case (state_q)
        ST_RUN: begin
          if (issue_s && is_halt_s) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // A flush means the HALT was on the wrong path.
          if (flush_f_ex) begin
            state_q <= ST_RUN;
          end else if (drain_done_s) begin
            state_q <= ST_HALTED;
          end
        end
        ST_HALTED: begin
          state_q <= ST_HALTED;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // A killed slot never stalls; it simply becomes a bubble.
  assign stall_2_if  = (hazard_s & ~flush_f_ex) | (state_q != ST_RUN);
  assign bubble_2_ex = ~issue_s;
  assign halted      = (state_q == ST_HALTED);
  assign sb_err      = sb_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed scenario tables with hand-derived expected outputs, followed by a
//   randomized run checked against an integer-array scoreboard model.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        v     = 1'b0;
  logic [31:0] inst  = 32'd0;
  logic        wb    = 1'b0;
  logic [4:0]  wa    = 5'd0;
  logic        fl    = 1'b0;
  logic        stall, bubble, halted, sberr;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  int pend[32];
  int mst;      // 0 run, 1 drain, 2 halted
  bit merr;

  localparam int MAXCNT = 3;

  typedef struct {
    bit          v;
    logic [31:0] inst;
    bit          wb;
    int          wa;
    bit          fl;
    bit          es, eb, eh, ee;
  } vec_t;

  hazard_ctrl #(.ADDR_LINE(5), .CNT_W(2)) dut (
    .clk             (clk),
    .reset           (reset),
    .inst_valid_f_if (v),
    .inst_f_if       (inst),
    .w_f_wb          (wb),
    .addr_in_f_wb    (wa),
    .flush_f_ex      (fl),
    .stall_2_if      (stall),
    .bubble_2_ex     (bubble),
    .halted          (halted),
    .sb_err          (sberr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input int op, input int rs, input int rt, input int rd);
    return {op[5:0], rs[4:0], rt[4:0], rd[4:0], 11'd0};
  endfunction

  function automatic vec_t mkv(input bit v_, input logic [31:0] i_, input bit wb_, input int wa_,
                               input bit fl_, input bit es_, input bit eb_, input bit eh_, input bit ee_);
    vec_t x;
    x.v = v_; x.inst = i_; x.wb = wb_; x.wa = wa_; x.fl = fl_;
    x.es = es_; x.eb = eb_; x.eh = eh_; x.ee = ee_;
    return x;
  endfunction

  function automatic void model_reset();
    foreach (pend[i]) pend[i] = 0;
    mst  = 0;
    merr = 1'b0;
  endfunction

  // Register 0 is encoded as "no operand": pend[0] stays 0 forever.
  function automatic void model_eval(output bit e_stall, output bit e_bubble, output bit e_halted,
                                     output bit e_err, output bit e_issue, output bit e_halt,
                                     output int e_dst);
    int op, rs, rt, rd, s1, s2;
    bit hz;
    op = int'(inst[31:26]); rs = int'(inst[25:21]); rt = int'(inst[20:16]); rd = int'(inst[15:11]);
    s1 = 0; s2 = 0; e_dst = 0; e_halt = 1'b0;
    if (op <= 11 && op % 2 == 0)       begin s1 = rs; s2 = rt; e_dst = rd; end
    else if (op <= 12)                 begin s1 = rs; e_dst = rt; end
    else if (op == 13 || op == 15)     begin s1 = rs; s2 = rt; end
    else if (op == 14 || op == 16)     s1 = rs;
    else if (op == 17)                 e_halt = 1'b1;
    hz       = v && (pend[s1] > 0 || pend[s2] > 0 || (e_dst != 0 && pend[e_dst] == MAXCNT));
    e_issue  = reset && v && !hz && !fl && mst == 0;
    e_stall  = (hz && !fl) || mst != 0;
    e_bubble = !e_issue;
    e_halted = (mst == 2);
    e_err    = merr;
  endfunction

  function automatic void model_step();
    bit st, bu, ha, er, is, hl;
    int d, total;
    if (!reset) return;
    model_eval(st, bu, ha, er, is, hl, d);
    if (wb && wa != 5'd0) begin
      if (pend[wa] > 0) pend[wa]--;
      else merr = 1'b1;
    end
    if (is && d != 0) pend[d]++;
    total = 0;
    foreach (pend[i]) total += pend[i];
    if (mst == 0 && is && hl) mst = 1;
    else if (mst == 1) begin
      if (fl) mst = 0;
      else if (total == 0) mst = 2;
    end
  endfunction

  task automatic apply(input vec_t x);
    v = x.v; inst = x.inst; wb = x.wb; wa = x.wa[4:0]; fl = x.fl;
  endtask

  task automatic idle();
    v = 1'b0; inst = 32'd0; wb = 1'b0; wa = 5'd0; fl = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    idle();
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    model_reset();
    v = 1'b1; inst = mk(0, 1, 2, 3);
    @(negedge clk);
    vectors++;
    if ({stall, bubble, halted, sberr} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_out0 got %b%b%b%b exp 0100", stall, bubble, halted, sberr);
    end
    @(posedge clk); @(negedge clk);
    vectors++;
    if ({stall, bubble, halted, sberr} !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_out1 got %b%b%b%b exp 0100", stall, bubble, halted, sberr);
    end
    idle();
    #2 reset = 1'b1;
    tick();
    // r3 must not have been counted while in reset
    v = 1'b1; inst = mk(1, 3, 4, 0);
    @(negedge clk);
    vectors++;
    if ({stall, bubble, halted, sberr} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_after got %b%b%b%b exp 0000", stall, bubble, halted, sberr);
    end
    tick();
    idle(); wb = 1'b1; wa = 5'd4;
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    vec_t t[$];
    t.push_back(mkv(1, mk(0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, mk(1, 3, 4, 0), 0, 0, 0, 1, 1, 0, 0));
    t.push_back(mkv(1, mk(1, 3, 4, 0), 0, 0, 0, 1, 1, 0, 0));
    t.push_back(mkv(1, mk(1, 3, 4, 0), 1, 3, 0, 1, 1, 0, 0));
    t.push_back(mkv(1, mk(1, 3, 4, 0), 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(0, 32'd0,          1, 4, 0, 0, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      vectors++;
      if ({stall, bubble, halted, sberr} !== {t[i].es, t[i].eb, t[i].eh, t[i].ee}) begin
        miscompares++;
        $display("FAIL back_to_back[%0d] stall/bubble/halted/sb_err got %b%b%b%b exp %b%b%b%b", i,
                 stall, bubble, halted, sberr, t[i].es, t[i].eb, t[i].eh, t[i].ee);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_r0_independent();
    vec_t t[$];
    t.push_back(mkv(1, mk(0, 1, 2, 0), 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, mk(0, 0, 0, 5), 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, mk(0, 7, 8, 6), 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(0, 32'd0,          1, 5, 0, 0, 1, 0, 0));
    t.push_back(mkv(0, 32'd0,          1, 6, 0, 0, 1, 0, 0));
    t.push_back(mkv(0, 32'd0,          1, 0, 0, 0, 1, 0, 0));
    t.push_back(mkv(0, 32'd0,          0, 0, 0, 0, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      vectors++;
      if ({stall, bubble, halted, sberr} !== {t[i].es, t[i].eb, t[i].eh, t[i].ee}) begin
        miscompares++;
        $display("FAIL r0_indep[%0d] stall/bubble/halted/sb_err got %b%b%b%b exp %b%b%b%b", i,
                 stall, bubble, halted, sberr, t[i].es, t[i].eb, t[i].eh, t[i].ee);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_saturation();
    vec_t t[$];
    logic [31:0] i7;
    i7 = mk(3, 1, 7, 0);
    t.push_back(mkv(1, i7, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, i7, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, i7, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, i7, 0, 0, 0, 1, 1, 0, 0));
    t.push_back(mkv(1, i7, 1, 7, 0, 1, 1, 0, 0));
    t.push_back(mkv(1, i7, 1, 7, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, i7, 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, i7, 0, 0, 0, 1, 1, 0, 0));
    t.push_back(mkv(0, 32'd0, 1, 7, 0, 0, 1, 0, 0));
    t.push_back(mkv(0, 32'd0, 1, 7, 0, 0, 1, 0, 0));
    t.push_back(mkv(0, 32'd0, 1, 7, 0, 0, 1, 0, 0));
    t.push_back(mkv(1, mk(0, 7, 7, 0), 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      vectors++;
      if ({stall, bubble, halted, sberr} !== {t[i].es, t[i].eb, t[i].eh, t[i].ee}) begin
        miscompares++;
        $display("FAIL saturation[%0d] stall/bubble/halted/sb_err got %b%b%b%b exp %b%b%b%b", i,
                 stall, bubble, halted, sberr, t[i].es, t[i].eb, t[i].eh, t[i].ee);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_flush();
    vec_t t[$];
    t.push_back(mkv(1, mk(0, 1, 2, 3), 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, mk(1, 3, 4, 0), 0, 0, 1, 0, 1, 0, 0));
    t.push_back(mkv(1, mk(1, 3, 4, 0), 0, 0, 0, 1, 1, 0, 0));
    t.push_back(mkv(0, 32'd0,          1, 3, 0, 0, 1, 0, 0));
    t.push_back(mkv(1, mk(0, 4, 4, 0), 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, mk(1, 1, 5, 0), 0, 0, 1, 0, 1, 0, 0));
    t.push_back(mkv(1, mk(0, 5, 5, 0), 0, 0, 0, 0, 0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      vectors++;
      if ({stall, bubble, halted, sberr} !== {t[i].es, t[i].eb, t[i].eh, t[i].ee}) begin
        miscompares++;
        $display("FAIL flush[%0d] stall/bubble/halted/sb_err got %b%b%b%b exp %b%b%b%b", i,
                 stall, bubble, halted, sberr, t[i].es, t[i].eb, t[i].eh, t[i].ee);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_halt();
    vec_t t[$];
    t.push_back(mkv(1, mk(0, 1, 2, 3),  0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, mk(0, 1, 2, 4),  0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, mk(17, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(0, 32'd0,           0, 0, 0, 1, 1, 0, 0));
    t.push_back(mkv(1, mk(0, 1, 2, 5),  1, 3, 0, 1, 1, 0, 0));
    t.push_back(mkv(0, 32'd0,           1, 4, 0, 1, 1, 0, 0));
    t.push_back(mkv(0, 32'd0,           0, 0, 0, 1, 1, 1, 0));
    t.push_back(mkv(1, mk(0, 1, 2, 6),  0, 0, 1, 1, 1, 1, 0));
    t.push_back(mkv(0, 32'd0,           1, 9, 0, 1, 1, 1, 0));
    t.push_back(mkv(0, 32'd0,           0, 0, 0, 1, 1, 1, 1));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      vectors++;
      if ({stall, bubble, halted, sberr} !== {t[i].es, t[i].eb, t[i].eh, t[i].ee}) begin
        miscompares++;
        $display("FAIL halt[%0d] stall/bubble/halted/sb_err got %b%b%b%b exp %b%b%b%b", i,
                 stall, bubble, halted, sberr, t[i].es, t[i].eb, t[i].eh, t[i].ee);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_drain_flush();
    vec_t t[$];
    do_reset();
    t.push_back(mkv(1, mk(0, 1, 2, 3),  0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(1, mk(17, 0, 0, 0), 0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(0, 32'd0,           0, 0, 0, 1, 1, 0, 0));
    t.push_back(mkv(0, 32'd0,           0, 0, 1, 1, 1, 0, 0));
    t.push_back(mkv(1, mk(0, 1, 2, 0),  0, 0, 0, 0, 0, 0, 0));
    t.push_back(mkv(0, 32'd0,           1, 3, 0, 0, 1, 0, 0));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      vectors++;
      if ({stall, bubble, halted, sberr} !== {t[i].es, t[i].eb, t[i].eh, t[i].ee}) begin
        miscompares++;
        $display("FAIL drain_flush[%0d] stall/bubble/halted/sb_err got %b%b%b%b exp %b%b%b%b", i,
                 stall, bubble, halted, sberr, t[i].es, t[i].eb, t[i].eh, t[i].ee);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_sberr_reset();
    vec_t t[$];
    t.push_back(mkv(0, 32'd0,           1, 9, 0, 0, 1, 0, 0));
    t.push_back(mkv(0, 32'd0,           0, 0, 0, 0, 1, 0, 1));
    t.push_back(mkv(1, mk(0, 1, 2, 3),  0, 0, 0, 0, 0, 0, 1));
    t.push_back(mkv(1, mk(17, 0, 0, 0), 0, 0, 0, 0, 0, 0, 1));
    t.push_back(mkv(0, 32'd0,           0, 0, 0, 1, 1, 0, 1));
    foreach (t[i]) begin
      apply(t[i]);
      @(negedge clk);
      vectors++;
      if ({stall, bubble, halted, sberr} !== {t[i].es, t[i].eb, t[i].eh, t[i].ee}) begin
        miscompares++;
        $display("FAIL sberr[%0d] stall/bubble/halted/sb_err got %b%b%b%b exp %b%b%b%b", i,
                 stall, bubble, halted, sberr, t[i].es, t[i].eb, t[i].eh, t[i].ee);
      end
      tick();
    end
    // asynchronous reset in the middle of DRAIN, away from any clock edge
    v = 1'b1; inst = mk(1, 3, 4, 0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({stall, bubble, halted, sberr} !== 4'b0100) begin
      miscompares++;
      $display("FAIL async_reset got %b%b%b%b exp 0100", stall, bubble, halted, sberr);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({stall, bubble, halted, sberr} !== 4'b0000) begin
      miscompares++;
      $display("FAIL post_async_reset got %b%b%b%b exp 0000", stall, bubble, halted, sberr);
    end
    tick();
    idle(); wb = 1'b1; wa = 5'd4;
    tick();
    idle();
  endtask

  task automatic test_random();
    int ops[11] = '{0, 2, 1, 3, 12, 13, 15, 14, 16, 17, 20};
    bit st, bu, ha, er, is, hl;
    int d, op;
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      if ((mst == 2 && $urandom_range(0, 3) == 0) || (c % 150 == 149)) do_reset();
      v  = ($urandom_range(0, 3) != 0);
      op = ops[$urandom_range(0, 10)];
      if (op == 17 && $urandom_range(0, 3) != 0) op = 0;
      inst = mk(op, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      fl = ($urandom_range(0, 9) == 0);
      wb = 1'b0; wa = 5'd0;
      if ($urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 19) == 0) begin
          wb = 1'b1; wa = 5'($urandom_range(0, 15));
        end else begin
          int s;
          s = $urandom_range(1, 31);
          for (int k = 0; k < 31; k++) begin
            int r;
            r = 1 + (s - 1 + k) % 31;
            if (!wb && pend[r] > 0) begin wb = 1'b1; wa = r[4:0]; end
          end
        end
      end
      @(negedge clk);
      model_eval(st, bu, ha, er, is, hl, d);
      vectors++;
      if ({stall, bubble, halted, sberr} !== {st, bu, ha, er}) begin
        miscompares++;
        $display("FAIL random[%0d] stall/bubble/halted/sb_err got %b%b%b%b exp %b%b%b%b", c,
                 stall, bubble, halted, sberr, st, bu, ha, er);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_back_to_back();
    test_r0_independent();
    test_saturation();
    test_flush();
    test_halt();
    test_drain_flush();
    test_sberr_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
